block_interleaver_pp: RTL and testbench

// - Parametrised row/column block interleaver for the turbo encoder datapath; successor to the fixed 4x4 single-buffer interleaver.
// - Ping-pong (two-bank) storage: one bank is written while the other is read, so blocks stream back-to-back with no gaps.
// - Per-block mode selects interleave or de-interleave.
// - Sits between the constituent-encoder input stage and the second RSC encoder; the decoder side uses it in de-interleave mode.

---
 rtl/block_interleaver_pp_if.sv | 18 +
 rtl/block_interleaver_pp.sv | 115 +++++++++++
 tb/tb_block_interleaver_pp.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_interleaver_pp_if.sv
// Stream interface for the ping-pong block interleaver.
// The master side feeds symbols in and accepts them out; the slave side is the interleaver.
interface block_interleaver_pp_if #(parameter int DW = 4);
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_first;
  logic          out_last;

  modport master (output mode, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_first, out_last);
  modport slave  (input  mode, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_first, out_last);
endinterface

// File: rtl/block_interleaver_pp.sv
// Two-bank row/column block interleaver: one bank fills while the other drains,
// so blocks of ROWS*COLS symbols stream back-to-back. Mode is chosen per block.
module block_interleaver_pp #(
  parameter int DW   = 4,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                clk,
  input  logic                rst,
  block_interleaver_pp_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int MW = $clog2(2 * N);

  logic [DW-1:0] mem [2*N];
  logic [1:0]    full, full_nxt, bmode;
  logic          wbank, rbank;
  logic [AW-1:0] wi, ri, wperm, rperm, waddr, raddr;
  logic [RW-1:0] wr, rr;
  logic [CW-1:0] wc, rc;
  logic [MW-1:0] wa, ra;
  logic          wr_en, rd_en, w_end, r_end;

  assign bus.in_ready = !full[wbank];
  assign wr_en = bus.in_valid && !full[wbank];
  assign rd_en = full[rbank] && (!bus.out_valid || bus.out_ready);
  assign w_end = (wi == AW'(N - 1));
  assign r_end = (ri == AW'(N - 1));

  // Nested row/col counters give (i % ROWS) * COLS + i / ROWS without a divider.
  assign wperm = AW'(wr) * AW'(COLS) + AW'(wc);
  assign rperm = AW'(rr) * AW'(COLS) + AW'(rc);

  // At wi==0 the bank's mode bit is stale, but both mappings give address 0 there.
  assign waddr = bmode[wbank] ? wperm : wi;
  assign raddr = bmode[rbank] ? ri : rperm;
  assign wa = wbank ? MW'(N) + MW'(waddr) : MW'(waddr);
  assign ra = rbank ? MW'(N) + MW'(raddr) : MW'(raddr);

  // Writer and reader only ever own opposite banks, so set and clear never collide.
  always_comb begin
    full_nxt = full;
    if (wr_en && w_end) full_nxt[wbank] = 1'b1;
    if (rd_en && r_end) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wa] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full          <= '0;
      bmode         <= '0;
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wi            <= '0;
      wr            <= '0;
      wc            <= '0;
      ri            <= '0;
      rr            <= '0;
      rc            <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      full <= full_nxt;

      if (wr_en) begin
        if (wi == '0) bmode[wbank] <= bus.mode;
        if (w_end) begin
          wbank <= ~wbank;
          wi    <= '0;
          wr    <= '0;
          wc    <= '0;
        end else begin
          wi <= wi + 1'b1;
          if (wr == RW'(ROWS - 1)) begin
            wr <= '0;
            wc <= wc + 1'b1;
          end else begin
            wr <= wr + 1'b1;
          end
        end
      end

      if (rd_en) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= mem[ra];
        bus.out_first <= (ri == '0);
        bus.out_last  <= r_end;
        if (r_end) begin
          rbank <= ~rbank;
          ri    <= '0;
          rr    <= '0;
          rc    <= '0;
        end else begin
          ri <= ri + 1'b1;
          if (rr == RW'(ROWS - 1)) begin
            rr <= '0;
            rc <= rc + 1'b1;
          end else begin
            rr <= rr + 1'b1;
          end
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_block_interleaver_pp.sv
// Scoreboard bench for the ping-pong interleaver: a matrix-based reference model
// queues expected output per completed block; a monitor pops on every output handshake.
module tb_block_interleaver_pp;
  localparam int DW   = 8;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_interleaver_pp_if #(.DW(DW)) bus();
  block_interleaver_pp #(.DW(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t          sb[$];
  logic [DW-1:0] cur[$];
  bit            cur_mode;
  int            checks = 0, errors = 0, cyc = 0;
  bit            rdy_rand = 1'b0, rdy_fix = 1'b1;
  bit            trk_on = 1'b0;
  int            trk_n = 0, trk_lo = 0, trk_hi = 0, ir_low = 0;

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Interleave: fill a ROWSxCOLS matrix row by row, read it column by column.
  // De-interleave: fill column by column, read row by row.
  function automatic void push_expected();
    logic [DW-1:0] m2 [ROWS][COLS];
    exp_t e;
    int k = 0;
    if (!cur_mode) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m2[r][c] = cur[r*COLS + c];
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++) begin
          e.data = m2[r][c]; e.first = (k == 0); e.last = (k == N - 1);
          sb.push_back(e); k++;
        end
    end else begin
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++) begin
          m2[r][c] = cur[k]; k++;
        end
      k = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          e.data = m2[r][c]; e.first = (k == 0); e.last = (k == N - 1);
          sb.push_back(e); k++;
        end
    end
  endfunction

  task automatic cycle_in(input bit v, input logic [DW-1:0] d, input bit m, output bit acc);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.mode     = m;
    @(negedge clk);
    acc = v && bus.in_ready;
    if (v && !bus.in_ready) ir_low++;
    if (acc) begin
      if (cur.size() == 0) cur_mode = m;
      cur.push_back(d);
      if (cur.size() == N) begin
        push_expected();
        cur.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  // pat: 0 random data, 1 ramp 0..N-1, 2 transposed ramp.
  // Mode is randomised on every symbol after the first to show it is ignored mid-block.
  task automatic send_block(input bit m, input bit gaps, input int n, input int pat);
    int i = 0, g = 0;
    bit a, v;
    logic [DW-1:0] d;
    while (i < n && g < 1000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = (pat == 1) ? DW'(i) :
          (pat == 2) ? DW'((i % ROWS) * COLS + i / ROWS) : DW'($urandom);
      cycle_in(v, d, (i == 0) ? m : 1'($urandom_range(0, 1)), a);
      if (a) i++;
      g++;
    end
    chk("send_complete", i, n);
  endtask

  task automatic drain();
    int g = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_left", int'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit hv = 1'b0;
    int hval = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (hv) begin
          chk("hold_valid", int'(bus.out_valid), 1);
          chk("hold_value", int'({bus.out_data, bus.out_first, bus.out_last}), hval);
        end
        hv   = bus.out_valid && !bus.out_ready;
        hval = int'({bus.out_data, bus.out_first, bus.out_last});
        if (trk_on && bus.out_valid) begin
          if (trk_n == 0) trk_lo = cyc;
          trk_hi = cyc;
          trk_n++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_data", int'(bus.out_data), int'(e.data));
            chk("out_first", int'(bus.out_first), int'(e.first));
            chk("out_last", int'(bus.out_last), int'(e.last));
          end
        end
      end
    end
  endtask

  task automatic rdy_drv();
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  endtask

  initial begin
    int acc_n;
    bit a;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode     = 1'b0;
    fork
      monitor();
      rdy_drv();
      begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_first_last", int'({bus.out_first, bus.out_last}), 0);
    @(posedge clk); #1;

    // Interleave ramp, then latency: invalid one cycle after the last accept, valid the next.
    send_block(1'b0, 1'b0, N, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_t2_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    drain();

    // De-interleave the transposed ramp back into order.
    send_block(1'b1, 1'b0, N, 2);
    drain();

    // Three back-to-back blocks: no input stall, contiguous output.
    ir_low = 0; trk_n = 0; trk_on = 1'b1;
    repeat (3) send_block(1'($urandom_range(0, 1)), 1'b0, N, 0);
    drain();
    trk_on = 1'b0;
    chk("b2b_in_ready_low", ir_low, 0);
    chk("b2b_out_count", trk_n, 3 * N);
    chk("b2b_out_span", trk_hi - trk_lo + 1, 3 * N);

    // Output fully stalled: two banks fill, then input backs up.
    rdy_fix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    acc_n = 0;
    for (int k = 0; k < 3 * N + 4; k++) begin
      cycle_in(1'b1, DW'($urandom), 1'b0, a);
      if (a) acc_n++;
    end
    bus.in_valid = 1'b0;
    chk("stall_accepted", acc_n, 2 * N);
    @(negedge clk);
    chk("stall_in_ready", int'(bus.in_ready), 0);
    chk("stall_out_valid", int'(bus.out_valid), 1);
    chk("stall_out_first", int'(bus.out_first), 1);
    if (sb.size() != 0) chk("stall_out_data", int'(bus.out_data), int'(sb[0].data));
    else chk("stall_sb_empty", 0, 1);
    @(posedge clk); #1;
    rdy_fix = 1'b1;
    drain();

    // Random downstream stalls and input gaps, mixed modes.
    rdy_rand = 1'b1;
    for (int b = 0; b < 10; b++) send_block(1'($urandom_range(0, 1)), 1'b1, N, 0);
    drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset partway into the second block discards everything in flight.
    send_block(1'b0, 1'b0, N, 0);
    send_block(1'b1, 1'b0, 5, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    cur.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", int'(bus.out_valid), 0);
    chk("rst2_in_ready", int'(bus.in_ready), 1);
    chk("rst2_first_last", int'({bus.out_first, bus.out_last}), 0);
    @(posedge clk); #1;
    send_block(1'b0, 1'b0, N, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
